// File: rtl/pcs_pkg.sv
// Shared definitions for the 64b/66b rx block-lock slice.
//   lock_state_t : block-lock FSM state encoding
//   SH_DATA/SH_CTRL : the two legal sync-header values
//   sh_valid()   : true for a legal sync header
package pcs_pkg;

    typedef enum logic [1:0] {
        HUNT      = 2'd0,
        SLIP_HOLD = 2'd1,
        LOCKED    = 2'd2
    } lock_state_t;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    function automatic logic sh_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/block_lock_ber_if.sv
// Bus between the rx gearbox side and the block-lock / BER monitor.
//   i_header[1:0]  sync header of the current 66b block
//   i_valid        header qualifier
//   i_ber_clear    synchronous clear of the errored-header counter
//   o_slip         one-cycle slip request back to the gearbox
//   o_block_lock   block lock achieved
//   o_hi_ber       high bit-error-rate flag
//   o_err_count    saturating errored-header count
// master = gearbox side (drives headers), slave = lock block.
interface block_lock_ber_if #(
    parameter int CNT_WIDTH = 16
) ();
    logic [1:0]           i_header;
    logic                 i_valid;
    logic                 i_ber_clear;
    logic                 o_slip;
    logic                 o_block_lock;
    logic                 o_hi_ber;
    logic [CNT_WIDTH-1:0] o_err_count;

    modport master (
        output i_header, i_valid, i_ber_clear,
        input  o_slip, o_block_lock, o_hi_ber, o_err_count
    );

    modport slave (
        input  i_header, i_valid, i_ber_clear,
        output o_slip, o_block_lock, o_hi_ber, o_err_count
    );
endinterface

// File: rtl/block_lock_ber_ber_monitor.sv
// Windowed high-BER detector plus saturating errored-header counter.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   enable           : block lock; when low the BER window is held cleared
//   i_valid          : header qualifier (advances the BER window timer)
//   invalid          : qualified invalid-header strobe
//   i_ber_clear      : synchronous clear of o_err_count
//   o_hi_ber         : high-BER flag, forced low whenever enable is low
//   o_err_count      : count of invalid headers seen while enabled
module ber_monitor #(
    parameter int BER_WINDOW = 3125,
    parameter int BER_LIMIT  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 enable,
    input  logic                 i_valid,
    input  logic                 invalid,
    input  logic                 i_ber_clear,
    output logic                 o_hi_ber,
    output logic [CNT_WIDTH-1:0] o_err_count
);
    localparam int TW = $clog2(BER_WINDOW) + 1;
    localparam int BW = $clog2(BER_LIMIT) + 1;
    localparam logic [TW-1:0] WIN_LAST = TW'(BER_WINDOW - 1);
    localparam logic [BW-1:0] LIMIT    = BW'(BER_LIMIT);

    logic [TW-1:0] timer_q;
    logic [BW-1:0] ber_cnt_q;
    logic          hi_q;
    logic          err_inc;

    assign err_inc = enable & invalid;

    // Window stage: timer wraps after BER_WINDOW valid headers; the
    // header on the wrap cycle is counted into the new window.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            timer_q   <= '0;
            ber_cnt_q <= '0;
            hi_q      <= 1'b0;
        end else if (!enable) begin
            timer_q   <= '0;
            ber_cnt_q <= '0;
            hi_q      <= 1'b0;
        end else if (i_valid) begin
            if (timer_q == WIN_LAST) begin
                timer_q   <= '0;
                ber_cnt_q <= invalid ? BW'(1) : '0;
                if (ber_cnt_q < LIMIT)
                    hi_q <= 1'b0;
                if (invalid && (LIMIT == BW'(1)))
                    hi_q <= 1'b1;
            end else begin
                timer_q <= timer_q + 1'b1;
                // Count stops at the limit; the flag is already set then.
                if (invalid && (ber_cnt_q < LIMIT)) begin
                    ber_cnt_q <= ber_cnt_q + 1'b1;
                    if (ber_cnt_q == LIMIT - 1'b1)
                        hi_q <= 1'b1;
                end
            end
        end
    end

    // Gating with enable drops the flag in the same cycle lock is lost.
    assign o_hi_ber = hi_q & enable;

    // Error-count stage: clear wins over increment, but a coincident
    // increment still lands, giving 1.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            o_err_count <= '0;
        else if (i_ber_clear)
            o_err_count <= err_inc ? CNT_WIDTH'(1) : '0;
        else if (err_inc && (o_err_count != {CNT_WIDTH{1'b1}}))
            o_err_count <= o_err_count + 1'b1;
    end

endmodule

// File: rtl/block_lock_ber.sv
// 64b/66b rx block-lock FSM with hysteretic loss-of-lock, gearbox slip
// control, windowed high-BER monitor and errored-header counter.
//   i_clk     : rx clock
//   i_reset_n : asynchronous active-low reset
//   bus       : block_lock_ber_if.slave (headers in; slip/lock/BER/count out)
module block_lock_ber
    import pcs_pkg::*;
#(
    parameter int LOCK_COUNT    = 64,
    parameter int WINDOW        = 64,
    parameter int INVALID_LIMIT = 16,
    parameter int SLIP_WAIT     = 2,
    parameter int BER_WINDOW    = 3125,
    parameter int BER_LIMIT     = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    block_lock_ber_if.slave bus
);
    localparam int GW = $clog2(LOCK_COUNT) + 1;
    localparam int WW = $clog2(WINDOW) + 1;
    localparam int BW = $clog2(INVALID_LIMIT) + 1;
    localparam int HW = $clog2(SLIP_WAIT) + 1;
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(INVALID_LIMIT - 1);
    // At least one valid cycle is always spent settling, which is what
    // keeps two slip pulses from ever being adjacent.
    localparam logic [HW-1:0] HOLD_LAST = HW'((SLIP_WAIT > 0) ? SLIP_WAIT - 1 : 0);

    lock_state_t   state_q, state_d;
    logic [GW-1:0] good_q, good_d;
    logic [WW-1:0] win_q, win_d;
    logic [BW-1:0] bad_q, bad_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          slip_d, slip_p1;
    logic          hdr_ok;
    logic          locked;

    assign hdr_ok = sh_valid(bus.i_header);
    assign locked = (state_q == LOCKED);

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        win_d   = win_q;
        bad_d   = bad_q;
        hold_d  = hold_q;
        slip_d  = 1'b0;
        if (bus.i_valid) begin
            case (state_q)
                HUNT: begin
                    if (!hdr_ok) begin
                        slip_d  = 1'b1;
                        good_d  = '0;
                        hold_d  = '0;
                        state_d = SLIP_HOLD;
                    end else if (good_q == GOOD_LAST) begin
                        good_d  = '0;
                        win_d   = '0;
                        bad_d   = '0;
                        state_d = LOCKED;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
                SLIP_HOLD: begin
                    if (hold_q >= HOLD_LAST) begin
                        hold_d  = '0;
                        state_d = HUNT;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                LOCKED: begin
                    // Loss of lock is checked before window end so the
                    // limit-reaching header on the last window slot still counts.
                    if (!hdr_ok && (bad_q == BAD_LAST)) begin
                        slip_d  = 1'b1;
                        win_d   = '0;
                        bad_d   = '0;
                        hold_d  = '0;
                        state_d = SLIP_HOLD;
                    end else if (win_q == WIN_LAST) begin
                        win_d = '0;
                        bad_d = '0;
                    end else begin
                        win_d = win_q + 1'b1;
                        bad_d = bad_q + BW'(!hdr_ok);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Register stage: FSM state, counters and the registered slip pulse.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= HUNT;
            good_q  <= '0;
            win_q   <= '0;
            bad_q   <= '0;
            hold_q  <= '0;
            slip_p1 <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            win_q   <= win_d;
            bad_q   <= bad_d;
            hold_q  <= hold_d;
            slip_p1 <= slip_d;
        end
    end

    assign bus.o_slip       = slip_p1;
    assign bus.o_block_lock = locked;

    ber_monitor #(
        .BER_WINDOW (BER_WINDOW),
        .BER_LIMIT  (BER_LIMIT),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_ber_monitor (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .enable      (locked),
        .i_valid     (bus.i_valid),
        .invalid     (bus.i_valid & ~hdr_ok),
        .i_ber_clear (bus.i_ber_clear),
        .o_hi_ber    (bus.o_hi_ber),
        .o_err_count (bus.o_err_count)
    );

endmodule

// File: tb/tb_block_lock_ber.sv
// Scoreboard bench for block_lock_ber: a driver issues headers and pushes
// the expected post-edge outputs from a behavioural model; a monitor
// compares them against the DUT on every falling edge.
module tb_block_lock_ber;
    localparam int LOCK_COUNT    = 64;
    localparam int WINDOW        = 64;
    localparam int INVALID_LIMIT = 16;
    localparam int SLIP_WAIT     = 2;
    localparam int BER_WINDOW    = 100;
    localparam int BER_LIMIT     = 16;
    localparam int CNT_WIDTH     = 4;
    localparam int ERR_MAX       = (1 << CNT_WIDTH) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    block_lock_ber_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

    block_lock_ber #(
        .LOCK_COUNT    (LOCK_COUNT),
        .WINDOW        (WINDOW),
        .INVALID_LIMIT (INVALID_LIMIT),
        .SLIP_WAIT     (SLIP_WAIT),
        .BER_WINDOW    (BER_WINDOW),
        .BER_LIMIT     (BER_LIMIT),
        .CNT_WIDTH     (CNT_WIDTH)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    typedef struct {
        int tgt;
        int slip;
        int lock;
        int hi;
        int err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: lock/window/settle bookkeeping in plain integers.
    bit m_locked, m_slip, m_hi;
    int m_run, m_settle, m_win, m_wbad, m_k, m_bcnt, m_err;

    function automatic void model_reset();
        m_locked = 0; m_slip = 0; m_hi = 0;
        m_run = 0; m_settle = 0; m_win = 0; m_wbad = 0;
        m_k = 0; m_bcnt = 0; m_err = 0;
    endfunction

    function automatic void model_step(input logic [1:0] hdr, input logic vld, input logic clr);
        bit good = (hdr == 2'b01) || (hdr == 2'b10);
        bit bad = vld && !good;
        bit was_locked = m_locked;
        m_slip = 0;
        if (clr) m_err = (was_locked && bad) ? 1 : 0;
        else if (was_locked && bad && m_err < ERR_MAX) m_err++;
        if (was_locked && vld) begin
            m_k++;
            if (m_k % BER_WINDOW == 0) begin
                if (m_bcnt < BER_LIMIT) m_hi = 0;
                m_bcnt = 0;
            end
            if (bad) begin
                m_bcnt++;
                if (m_bcnt >= BER_LIMIT) m_hi = 1;
            end
        end
        if (vld) begin
            if (m_settle > 0) begin
                m_settle--;
            end else if (!m_locked) begin
                if (good) begin
                    m_run++;
                    if (m_run == LOCK_COUNT) begin
                        m_locked = 1; m_run = 0; m_win = 0; m_wbad = 0;
                        m_k = 0; m_bcnt = 0; m_hi = 0;
                    end
                end else begin
                    m_run = 0; m_slip = 1; m_settle = SLIP_WAIT;
                end
            end else begin
                m_win++;
                m_wbad += bad ? 1 : 0;
                if (m_wbad == INVALID_LIMIT) begin
                    m_locked = 0; m_slip = 1; m_settle = SLIP_WAIT;
                    m_win = 0; m_wbad = 0; m_k = 0; m_bcnt = 0; m_hi = 0;
                end else if (m_win == WINDOW) begin
                    m_win = 0; m_wbad = 0;
                end
            end
        end
    endfunction

    function automatic logic [1:0] rand_good();
        return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] rand_bad();
        return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    endfunction

    // Drive one cycle; called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic [1:0] hdr, input logic vld, input logic clr);
        exp_t e;
        bus.i_header    = hdr;
        bus.i_valid     = vld;
        bus.i_ber_clear = clr;
        model_step(hdr, vld, clr);
        e.tgt  = cyc + 1;
        e.slip = int'(m_slip);
        e.lock = int'(m_locked);
        e.hi   = int'(m_hi && m_locked);
        e.err  = m_err;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_slip"}, int'(bus.o_slip), 0);
        check({tag, "_lock"}, int'(bus.o_block_lock), 0);
        check({tag, "_hiber"}, int'(bus.o_hi_ber), 0);
        check({tag, "_err"}, int'(bus.o_err_count), 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ber_clear = 1'b0;
        #1;
        check_zero(tag);
        q.delete();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compare every expectation that targets the edge just past.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].tgt <= cyc) begin
                exp_t e;
                e = q.pop_front();
                if (e.tgt != cyc) begin
                    check("sb_stale", e.tgt, cyc);
                end else begin
                    check("sb_slip", int'(bus.o_slip), e.slip);
                    check("sb_lock", int'(bus.o_block_lock), e.lock);
                    check("sb_hiber", int'(bus.o_hi_ber), e.hi);
                    check("sb_err", int'(bus.o_err_count), e.err);
                end
            end
        end
    end

    initial begin
        int slips;
        int lost;
        int budget;
        bit aligned;
        bus.i_header = 2'b00;
        bus.i_valid = 1'b0;
        bus.i_ber_clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Lock acquisition: lock rises on the edge of the 64th valid header.
        for (int i = 0; i < LOCK_COUNT - 1; i++) step(rand_good(), 1'b1, 1'b0);
        check("t1_prelock", int'(bus.o_block_lock), 0);
        step(rand_good(), 1'b1, 1'b0);
        check("t1_lock", int'(bus.o_block_lock), 1);

        // Locked with i_valid gaps.
        for (int i = 0; i < 200; i++)
            step(rand_good(), ($urandom_range(0, 3) != 0), 1'b0);

        // 15 invalid in one window hold lock; 16 drop it.
        while (m_win != 0) step(rand_good(), 1'b1, 1'b0);
        for (int i = 0; i < WINDOW; i++)
            step((i % 4 == 1 && i < 60) ? rand_bad() : rand_good(), 1'b1, 1'b0);
        check("t3_hold15", int'(bus.o_block_lock), 1);
        for (int i = 0; i < INVALID_LIMIT - 1; i++) step(rand_bad(), 1'b1, 1'b0);
        check("t3_still", int'(bus.o_block_lock), 1);
        step(rand_bad(), 1'b1, 1'b0);
        check("t3_drop", int'(bus.o_block_lock), 0);
        check("t3_slip", int'(bus.o_slip), 1);
        step(rand_good(), 1'b1, 1'b0);
        check("t3_slip_once", int'(bus.o_slip), 0);
        for (int i = 0; i < SLIP_WAIT - 1 + LOCK_COUNT; i++) step(rand_good(), 1'b1, 1'b0);
        check("t3_relock", int'(bus.o_block_lock), 1);

        // BER window: 16 spread invalid set hi-BER; 3 next window clear it.
        while (m_k % BER_WINDOW != 0) step(rand_good(), 1'b1, 1'b0);
        for (int i = 0; i < BER_WINDOW; i++) begin
            step((i % 6 == 0 && i <= 90) ? rand_bad() : rand_good(), 1'b1, 1'b0);
            if (i == 84) check("t4_below", int'(bus.o_hi_ber), 0);
            if (i == 90) check("t4_hi_set", int'(bus.o_hi_ber), 1);
        end
        check("t4_hi_wrap", int'(bus.o_hi_ber), 1);
        for (int i = 0; i < BER_WINDOW; i++) begin
            step((i == 10 || i == 20 || i == 30) ? rand_bad() : rand_good(), 1'b1, 1'b0);
            if (i == BER_WINDOW - 2) check("t4_hi_keep", int'(bus.o_hi_ber), 1);
        end
        check("t4_hi_clr", int'(bus.o_hi_ber), 0);

        // Error counter saturation and clear behaviour.
        step(rand_good(), 1'b1, 1'b1);
        check("t5_clr0", int'(bus.o_err_count), 0);
        while (m_win != 0) step(rand_good(), 1'b1, 1'b0);
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < WINDOW; i++)
                step((i < 10) ? rand_bad() : rand_good(), 1'b1, 1'b0);
        check("t5_sat", int'(bus.o_err_count), ERR_MAX);
        step(rand_bad(), 1'b0, 1'b0);
        check("t5_frozen", int'(bus.o_err_count), ERR_MAX);
        step(rand_bad(), 1'b1, 1'b1);
        check("t5_clr_inc", int'(bus.o_err_count), 1);
        step(rand_good(), 1'b1, 1'b1);
        check("t5_clr_only", int'(bus.o_err_count), 0);

        // Async reset mid-window while locked, and with a slip pending.
        for (int i = 0; i < 20; i++) step(rand_good(), 1'b1, 1'b0);
        do_reset("t6_rst");
        step(rand_bad(), 1'b1, 1'b0);
        check("t6_hunt_slip", int'(bus.o_slip), 1);
        do_reset("t6_rst_slip");
        for (int i = 0; i < LOCK_COUNT; i++) step(rand_good(), 1'b1, 1'b0);
        check("t6_relock", int'(bus.o_block_lock), 1);

        // Gearbox loopback with a 5-bit offset: each slip shifts one bit.
        do_reset("t7_rst");
        slips = 0;
        budget = 0;
        while (!bus.o_block_lock && budget < 5000) begin
            aligned = ((5 + slips) % 66 == 0);
            step(aligned ? rand_good() : 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) != 0), 1'b0);
            if (bus.o_slip) slips++;
            budget++;
        end
        check("t7_locked", int'(bus.o_block_lock), 1);
        check("t7_slips_ok", int'(slips <= 66), 1);
        lost = 0;
        for (int i = 0; i < 10000; i++) begin
            step(rand_good(), 1'b1, 1'b0);
            if (!bus.o_block_lock) lost++;
        end
        check("t7_held", lost, 0);

        // Random mix of headers, valid gaps and clears.
        for (int i = 0; i < 2000; i++)
            step(($urandom_range(0, 19) == 0) ? rand_bad() : rand_good(),
                 ($urandom_range(0, 4) != 0), ($urandom_range(0, 31) == 0));

        bus.i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
